serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 132 +++++++++++++
 tb/tb_serial_subtractor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, one full-subtractor slice per cycle LSB first; done pulses WIDTH cycles after start is taken.
// Start is taken only in IDLE or DONE and is ignored while busy; all outputs are registered.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] d_sh;
  logic [CNT_W-1:0] bit_cnt;
  logic             br;

  logic             ai;
  logic             bi;
  logic             d;
  logic             br_nxt;
  logic [WIDTH-1:0] d_cat;

  // Current bit slice; d_cat is the difference as it will look once this bit is shifted in.
  assign ai     = a_sh[0];
  assign bi     = b_sh[0];
  assign d      = ai ^ bi ^ br;
  assign br_nxt = (~ai & bi) | (~(ai ^ bi) & br);
  assign d_cat  = {d, d_sh};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        last_bit = (bit_cnt == LAST_BIT);
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh    <= '0;
      b_sh    <= '0;
      d_sh    <= '0;
      bit_cnt <= '0;
      br      <= 1'b0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      d_sh    <= '0;
      bit_cnt <= '0;
      br      <= 1'b0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      d_sh <= d_cat[WIDTH-1:1];
      br   <= br_nxt;
      // Counter parks on the terminal value rather than wrapping.
      if (!last_bit) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  // On the last slice a_sh[0]/b_sh[0] hold the operand MSBs, so overflow needs no extra state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= last_bit;
      if (last_bit) begin
        diff       <= d_cat;
        borrow_out <= br_nxt;
        ovf        <= (ai ^ bi) & (ai ^ d);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH = 8: results, timing, ignored/back-to-back start, async reset.
module tb_serial_subtractor;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_diff"}, {24'd0, diff}, 32'd0);
    check({tag, "_borrow"}, {31'd0, borrow_out}, 32'd0);
    check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  // One operation: start sampled at edge k, operands scrambled afterwards; observe #1 after each edge.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ed, input logic eb, input logic eo);
    int busy_n;
    int done_n;
    int done_at;
    logic [7:0] d_seen;
    logic b_seen;
    logic o_seen;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    d_seen  = '0;
    b_seen  = 1'b0;
    o_seen  = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = ~av; b = ~bv;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = i;
          d_seen  = diff;
          b_seen  = borrow_out;
          o_seen  = ovf;
        end
      end
      @(posedge clk); #1;
    end
    check({tag, "_busy_cycles"}, busy_n, 8);
    check({tag, "_done_at"}, done_at, 8);
    check({tag, "_done_count"}, done_n, 1);
    check({tag, "_diff"}, {24'd0, d_seen}, {24'd0, ed});
    check({tag, "_borrow"}, {31'd0, b_seen}, {31'd0, eb});
    check({tag, "_ovf"}, {31'd0, o_seen}, {31'd0, eo});
    check({tag, "_diff_hold"}, {24'd0, diff}, {24'd0, ed});
  endtask

  initial begin
    int d1_at;
    int d2_at;
    int done_n;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] f1;
    logic [1:0] f2;

    reset = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    #1;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    run_op("sub_100_37", 8'd100, 8'd37, 8'd63, 1'b0, 1'b0);
    run_op("sub_37_100", 8'd37, 8'd100, 8'hC1, 1'b1, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("sub_00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("sub_00_ff", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);

    // Re-pulse during RUN must be ignored; start held into DONE starts 200-50.
    d1_at = -1; d2_at = -1; done_n = 0;
    d1 = '0; d2 = '0; f1 = '0; f2 = '0;
    @(posedge clk); #1;
    start = 1'b1; a = 8'd50; b = 8'd20;
    @(posedge clk); #1;
    start = 1'b0; a = 8'd0; b = 8'd0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        done_n++;
        if (d1_at < 0) begin
          d1_at = i; d1 = diff; f1 = {borrow_out, ovf};
        end else if (d2_at < 0) begin
          d2_at = i; d2 = diff; f2 = {borrow_out, ovf};
        end
      end
      if (i == 2) begin
        start = 1'b1; a = 8'd5; b = 8'd9;
      end else if (i == 3) begin
        start = 1'b0; a = 8'd0; b = 8'd0;
      end else if (i == 7) begin
        start = 1'b1; a = 8'd200; b = 8'd50;
      end else if (i == 9) begin
        start = 1'b0; a = 8'd0; b = 8'd0;
      end
      @(posedge clk); #1;
    end
    check("b2b_first_done_at", d1_at, 8);
    check("b2b_first_diff", {24'd0, d1}, 32'd30);
    check("b2b_first_flags", {30'd0, f1}, 32'd0);
    check("b2b_gap", d2_at - d1_at, 9);
    check("b2b_second_diff", {24'd0, d2}, 32'd150);
    check("b2b_second_flags", {30'd0, f2}, 32'd0);
    check("b2b_done_count", done_n, 2);

    // Asynchronous reset in the middle of cycle 4 of a run.
    @(posedge clk); #1;
    start = 1'b1; a = 8'd100; b = 8'd37;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    check("midrun_busy_before_reset", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    done_n = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) done_n++;
      @(posedge clk); #1;
    end
    check("after_reset_no_activity", done_n, 0);
    check("after_reset_diff", {24'd0, diff}, 32'd0);

    run_op("post_reset", 8'd100, 8'd37, 8'd63, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
